pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 3-stage core (IF, ID, EX). It sits beside the ID/EX forwarding logic and drives the stage-register hold and flush controls. It inserts a bubble on load-use hazards that forwarding cannot cover, holds the pipe during multi-cycle divide and stalled bus accesses, and performs a two-cycle flush on taken jumps. Its outputs go directly to the PC register, the `if_id` and `id_ex` registers, and the jump mux in the PC unit.

## Interface
Parameters:
- `BUS_TIMEOUT`, default 255: bus-wait cycles before abort; 8-bit counter, legal range 1–255.

Ports:
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-low reset.
- `id_reg1_raddr_i` input 5: ID rs1 address.
- `id_reg2_raddr_i` input 5: ID rs2 address.
- `id_reg1_re_i` input 1: ID actually reads rs1.
- `id_reg2_re_i` input 1: ID actually reads rs2.
- `ex_reg_waddr_i` input 5: EX destination register.
- `ex_reg_we_i` input 1: EX writes a register.
- `ex_mem_load_i` input 1: EX instruction is a load (data available next cycle).
- `ex_jump_i` input 1: EX resolved a taken jump or branch.
- `ex_jump_addr_i` input 32: jump target.
- `div_start_i` input 1: EX launched a divide.
- `div_ready_i` input 1: divider result valid (single-cycle pulse).
- `bus_req_i` input 1: EX data-bus request.
- `bus_gnt_i` input 1: bus grant/ack.
- `int_hold_i` input 1: CLINT requests front-end hold.
- `stall_o` output 3: hold controls `{id_ex, if_id, pc}`.
- `flush_o` output 1: clears `if_id` and `id_ex` to NOP.
- `bubble_o` output 1: loads NOP into `id_ex` only.
- `jump_o` output 1: PC takes `jump_addr_o`.
- `jump_addr_o` output 32: PC target.
- `bus_timeout_o` output 1: sticky bus-abort flag.

## Operation
- FSM states: IDLE, DIV_WAIT, BUS_WAIT, FLUSH.
- Priority inside IDLE: jump > divide > bus wait > load-use.
- IDLE transitions and outputs:
  - `ex_jump_i`: `jump_o`=1, `jump_addr_o`=`ex_jump_addr_i`, `flush_o`=1, stall 0; next state FLUSH.
  - Else `div_start_i`: `stall_o`=3'b111; next state DIV_WAIT.
  - Else `bus_req_i & !bus_gnt_i`: `stall_o`=3'b111, counter ← 1; next state BUS_WAIT.
  - Else load-use, defined as `ex_mem_load_i & ex_reg_we_i & ex_reg_waddr_i!=0 & ((id_reg1_re_i & raddr1==waddr) | (id_reg2_re_i & raddr2==waddr))`: `stall_o`=3'b011 and `bubble_o`=1 for that cycle only; remain in IDLE.
- DIV_WAIT: `stall_o`=3'b111 until `div_ready_i`. The `div_ready_i` cycle drives stall 0 and returns to IDLE. `ex_jump_i` is ignored here because EX is held.
- BUS_WAIT: `stall_o`=3'b111; counter increments each cycle.
  - `bus_gnt_i`: stall 0 that cycle, go to IDLE, clear counter.
  - Timeout (see Configuration): go to IDLE.
- FLUSH: `flush_o`=1, stall 0, `jump_o`=0; then IDLE. Inputs are ignored (ID/EX already hold NOP).
- `int_hold_i` overlay, any state: OR 3'b011 into `stall_o`. FSM transitions are unaffected. In FLUSH, `flush_o` still wins over stall for the `if_id` contents.
- `jump_addr_o` is 0 whenever `jump_o`=0.

## Timing
- While `rst`=0 at a rising edge: state ← IDLE, counter ← 0, `bus_timeout_o` ← 0.
- While `rst` is low, all outputs are forced to 0 combinationally. A reset during DIV_WAIT or BUS_WAIT returns to IDLE at that edge; there is no divide or bus cleanup.
- Load-use costs exactly 1 bubble cycle. Jump penalty is 2 cycles: the detect cycle plus FLUSH.
- All outputs are combinational from state and inputs; only state, counter and the sticky flag are registered.
- `div_start_i` and `div_ready_i` in the same cycle in IDLE: treated as a completed divide; no stall.
- `bus_req_i & bus_gnt_i` in the same IDLE cycle: no stall.

## Configuration
- `PIPE_CTRL_BUS_TIMEOUT_EN` defined:
  - In BUS_WAIT, a counter reaching `BUS_TIMEOUT` without grant sets `bus_timeout_o`=1 (sticky until reset).
  - Stall is released that cycle and the FSM returns to IDLE.
- Not defined: the counter is not built, `bus_timeout_o` is tied 0, and BUS_WAIT lasts until `bus_gnt_i` with no limit.

## Test plan
- Load-use: EX load with `ex_reg_waddr_i`=5, `id_reg1_raddr_i`=5, `id_reg1_re_i`=1 → exactly one cycle of `stall_o`=3'b011 and `bubble_o`=1. The same case with waddr=0 → no stall.
- Jump: `ex_jump_i`=1 with target 0x0000_0100 → cycle N has `jump_o`=1, `jump_addr_o`=0x100, `flush_o`=1; cycle N+1 has `flush_o`=1, `jump_o`=0; cycle N+2 is IDLE.
- Divide: `div_start_i` pulse, `div_ready_i` 33 cycles later → `stall_o`=3'b111 for 33 cycles, then 0 in the ready cycle.
- Bus wait: `bus_req_i`=1, grant after 4 cycles → 4 stall cycles. With the macro defined, `BUS_TIMEOUT`=8 and no grant → `bus_timeout_o` rises after 8 stall cycles and stays high.
- Priority/reset: jump, divide start and load-use hazard in the same cycle → only the jump path fires. Driving `rst`=0 mid-DIV_WAIT → IDLE after the edge and all outputs 0.
- `int_hold_i` held in IDLE → `stall_o`=3'b011. Adding `div_start_i` → 3'b111.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 3-stage pipeline hold/flush/bubble sequencer
// Optional bus-wait abort counter enabled by PIPE_CTRL_BUS_TIMEOUT_EN.
module pipe_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  input  logic        id_reg1_re_i,
  input  logic        id_reg2_re_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        ex_reg_we_i,
  input  logic        ex_mem_load_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        div_start_i,
  input  logic        div_ready_i,
  input  logic        bus_req_i,
  input  logic        bus_gnt_i,
  input  logic        int_hold_i,
  output logic [2:0]  stall_o,
  output logic        flush_o,
  output logic        bubble_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        bus_timeout_o
);

  typedef enum logic [1:0] {IDLE, DIV_WAIT, BUS_WAIT, FLUSH} state_e;
  localparam logic [7:0] TIMEOUT_VAL = 8'(BUS_TIMEOUT);

  state_e     state_q, state_d;
  logic       load_use;
  logic       bus_to_hit;
  logic       timeout_flag;
  logic [2:0] stall_fsm;
  logic       flush_fsm, bubble_fsm, jump_fsm;

  assign load_use = ex_mem_load_i & ex_reg_we_i & (ex_reg_waddr_i != 5'd0) &
                    ((id_reg1_re_i & (id_reg1_raddr_i == ex_reg_waddr_i)) |
                     (id_reg2_re_i & (id_reg2_raddr_i == ex_reg_waddr_i)));

  always_comb begin
    state_d    = state_q;
    stall_fsm  = 3'b000;
    flush_fsm  = 1'b0;
    bubble_fsm = 1'b0;
    jump_fsm   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_jump_i) begin
          jump_fsm  = 1'b1;
          flush_fsm = 1'b1;
          state_d   = FLUSH;
        end else if (div_start_i) begin
          // A divide that completes in its launch cycle needs no hold.
          if (!div_ready_i) begin
            stall_fsm = 3'b111;
            state_d   = DIV_WAIT;
          end
        end else if (bus_req_i && !bus_gnt_i) begin
          stall_fsm = 3'b111;
          state_d   = BUS_WAIT;
        end else if (load_use) begin
          stall_fsm  = 3'b011;
          bubble_fsm = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (div_ready_i) state_d = IDLE;
        else             stall_fsm = 3'b111;
      end
      BUS_WAIT: begin
        if (bus_gnt_i || bus_to_hit) state_d = IDLE;
        else                         stall_fsm = 3'b111;
      end
      FLUSH: begin
        flush_fsm = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  logic [7:0] bus_cnt_q, bus_cnt_d;
  logic       bus_timeout_q, bus_timeout_d;

  assign bus_to_hit   = (bus_cnt_q == TIMEOUT_VAL);
  assign timeout_flag = bus_timeout_q;

  always_comb begin
    bus_cnt_d = 8'd0;
    if (state_d == BUS_WAIT)
      bus_cnt_d = (state_q == BUS_WAIT) ? bus_cnt_q + 8'd1 : 8'd1;
    bus_timeout_d = bus_timeout_q | ((state_q == BUS_WAIT) & ~bus_gnt_i & bus_to_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_cnt_q     <= 8'd0;
      bus_timeout_q <= 1'b0;
    end else begin
      bus_cnt_q     <= bus_cnt_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_VAL;
  assign bus_to_hit     = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  // Reset masks every output; the CLINT hold overlays whatever the FSM drives.
  always_comb begin
    stall_o       = 3'b000;
    flush_o       = 1'b0;
    bubble_o      = 1'b0;
    jump_o        = 1'b0;
    jump_addr_o   = 32'd0;
    bus_timeout_o = 1'b0;
    if (rst) begin
      stall_o       = stall_fsm | (int_hold_i ? 3'b011 : 3'b000);
      flush_o       = flush_fsm;
      bubble_o      = bubble_fsm;
      jump_o        = jump_fsm;
      jump_addr_o   = jump_fsm ? ex_jump_addr_i : 32'd0;
      bus_timeout_o = timeout_flag;
    end
  end

endmodule
